// File: rtl/fdiv_seq.sv
// fdiv_seq: valid/ready issue/result stage wrapped around a combinational single-precision divider.
// Build option FDIV_SPECIAL_EN adds zero-operand special cases and a divide-by-zero flag at result capture.

module fdiv (
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] y
);
    logic        sign_s;
    logic [25:0] rem_s;
    logic [25:0] div_s;
    logic [25:0] q_s;
    logic [9:0]  exp_s;
    logic [24:0] man_s;
    logic        unused_s;

    assign unused_s = man_s[23];

    // Restoring mantissa division, round on the first dropped bit, then exponent range handling
    always_comb begin
        sign_s = a[31] ^ b[31];
        div_s  = {2'b00, 1'b1, b[22:0]};
        rem_s  = {2'b00, 1'b1, a[22:0]};
        q_s    = 26'd0;
        for (int i = 25; i >= 0; i--) begin
            if (rem_s >= div_s) begin
                q_s[i] = 1'b1;
                rem_s  = rem_s - div_s;
            end else begin
                q_s[i] = 1'b0;
            end
            rem_s = {rem_s[24:0], 1'b0};
        end
        exp_s = {2'b00, a[30:23]} - {2'b00, b[30:23]} + 10'd127;
        if (q_s[25]) begin
            man_s = {1'b0, q_s[25:2]} + {24'd0, q_s[1]};
        end else begin
            man_s = {1'b0, q_s[24:1]} + {24'd0, q_s[0]};
            exp_s = exp_s - 10'd1;
        end
        // rounding carried out of the mantissa
        if (man_s[24]) begin
            man_s = {1'b0, man_s[24:1]};
            exp_s = exp_s + 10'd1;
        end else begin
            man_s = man_s;
        end
        if (a[30:23] == 8'd0) begin
            y = {sign_s, 31'd0};
        end else if (exp_s[9] || (exp_s == 10'd0)) begin
            y = {sign_s, 31'd0};
        end else if (exp_s >= 10'd255) begin
            y = {sign_s, 8'hFF, 23'd0};
        end else begin
            y = {sign_s, exp_s[7:0], man_s[22:0]};
        end
    end
endmodule

module fdiv_seq #(
    parameter int LATENCY = 3,
    parameter int TAG_W   = 6
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      x1,
    input  logic [31:0]      x2,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      y,
    output logic [TAG_W-1:0] out_tag,
    output logic             dz_flag,
    output logic             busy
);
    typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_t;

    state_t           state_r, state_next_s;
    logic [3:0]       cnt_r, cnt_next_s;
    logic             accept_s, capture_s;
    logic [31:0]      x1_r, x2_r;
    logic [TAG_W-1:0] tag_r;
    logic [31:0]      core_y_s, cap_y_s;

    fdiv u_fdiv (.a(x1_r), .b(x2_r), .y(core_y_s));

    assign busy = (state_r != IDLE);

    // State and latency counter register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r <= IDLE;
            cnt_r   <= 4'd0;
        end else begin
            state_r <= state_next_s;
            cnt_r   <= cnt_next_s;
        end
    end

    // Next-state, handshake and capture strobes; flush overrides everything
    always_comb begin
        state_next_s = state_r;
        cnt_next_s   = cnt_r;
        accept_s     = 1'b0;
        capture_s    = 1'b0;
        in_ready     = 1'b0;
        if (flush) begin
            state_next_s = IDLE;
        end else begin
            case (state_r)
                IDLE: begin
                    in_ready = 1'b1;
                    if (in_valid) begin
                        accept_s     = 1'b1;
                        cnt_next_s   = 4'(LATENCY - 1);
                        state_next_s = CALC;
                    end else begin
                        state_next_s = IDLE;
                    end
                end
                CALC: begin
                    if (cnt_r != 4'd0) begin
                        cnt_next_s = cnt_r - 4'd1;
                    end else begin
                        capture_s    = 1'b1;
                        state_next_s = DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        in_ready = 1'b1;
                        if (in_valid) begin
                            accept_s     = 1'b1;
                            cnt_next_s   = 4'(LATENCY - 1);
                            state_next_s = CALC;
                        end else begin
                            state_next_s = IDLE;
                        end
                    end else begin
                        state_next_s = DONE;
                    end
                end
                default: state_next_s = IDLE;
            endcase
        end
    end

    // Operand, result and valid registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            x1_r      <= 32'd0;
            x2_r      <= 32'd0;
            tag_r     <= '0;
            y         <= 32'd0;
            out_tag   <= '0;
            out_valid <= 1'b0;
        end else begin
            if (accept_s) begin
                x1_r  <= x1;
                x2_r  <= x2;
                tag_r <= in_tag;
            end
            if (capture_s) begin
                y       <= cap_y_s;
                out_tag <= tag_r;
            end
            if (flush) begin
                out_valid <= 1'b0;
            end else if (capture_s) begin
                out_valid <= 1'b1;
            end else if ((state_r == DONE) && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

`ifdef FDIV_SPECIAL_EN
    logic cap_dz_s;

    // Zero-exponent operands bypass the divider
    always_comb begin
        cap_y_s  = core_y_s;
        cap_dz_s = 1'b0;
        if ((x1_r[30:23] == 8'd0) && (x2_r[30:23] == 8'd0)) begin
            cap_y_s  = 32'h7FC0_0000;
            cap_dz_s = 1'b1;
        end else if (x2_r[30:23] == 8'd0) begin
            cap_y_s  = {x1_r[31] ^ x2_r[31], 8'hFF, 23'd0};
            cap_dz_s = 1'b1;
        end else if (x1_r[30:23] == 8'd0) begin
            cap_y_s  = {x1_r[31] ^ x2_r[31], 31'd0};
            cap_dz_s = 1'b0;
        end else begin
            cap_y_s  = core_y_s;
            cap_dz_s = 1'b0;
        end
    end

    // Divide-by-zero flag register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            dz_flag <= 1'b0;
        end else if (capture_s) begin
            dz_flag <= cap_dz_s;
        end
    end
`else
    assign cap_y_s = core_y_s;
    assign dz_flag = 1'b0;
`endif
endmodule

// File: tb/tb_fdiv_seq.sv
// Scoreboard bench for fdiv_seq: expected results queued at accept, compared at the output handshake.

module tb_fdiv_seq;
    localparam int LAT = 3;

    logic        clk = 1'b0;
    logic        rstn, flush, in_valid, in_ready, out_valid, out_ready, dz_flag, busy;
    logic [31:0] x1, x2, y;
    logic [5:0]  in_tag, out_tag;

    typedef struct {
        logic [31:0] y;
        logic [5:0]  tag;
        logic        dz;
        int unsigned tol;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int   err_cnt = 0;
    int   chk_cnt = 0;
    int   cyc = 0;
    int   c0, c1, c2, hi_cnt;
    bit   seen;

    fdiv_seq #(.LATENCY(LAT), .TAG_W(6)) dut (
        .clk(clk), .rstn(rstn), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .x1(x1), .x2(x2), .in_tag(in_tag), .out_valid(out_valid), .out_ready(out_ready),
        .y(y), .out_tag(out_tag), .dz_flag(dz_flag), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp,
                         input int unsigned tol = 0);
        logic [31:0] d;
        chk_cnt++;
        d = (obs > exp) ? obs - exp : exp - obs;
        if ($isunknown(obs) || (d > tol)) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h (tol %0d)", tag, obs, exp, tol);
        end
    endtask

    // Scoreboard: compare at every output handshake
    always @(negedge clk) begin
        if (rstn && out_valid && out_ready) begin
            if (q.size() == 0) begin
                check("spurious_out", 32'd0, 32'd1);
            end else begin
                e = q.pop_front();
                check("y", y, e.y, e.tol);
                check("out_tag", {26'd0, out_tag}, {26'd0, e.tag});
                check("dz_flag", {31'd0, dz_flag}, {31'd0, e.dz});
            end
        end
    end

    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [5:0] t,
                        input logic [31:0] ey, input logic edz, input int unsigned tol,
                        input bit push, output int acc_cyc);
        bit got;
        got = 1'b0;
        acc_cyc = 0;
        x1 = a; x2 = b; in_tag = t; in_valid = 1'b1;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk);
            if (in_ready) begin
                got = 1'b1;
                acc_cyc = cyc;
                if (push) q.push_back('{ey, t, edz, tol});
            end
        end
        check("accept", {31'd0, got}, 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 100 && q.size() != 0; i++) @(negedge clk);
        check("drain", q.size(), 32'd0);
        @(posedge clk); #1;
    endtask

    task automatic wait_valid();
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            seen = out_valid;
        end
        check("wait_valid", {31'd0, seen}, 32'd1);
    endtask

    initial begin
        rstn = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        x1 = 32'd0; x2 = 32'd0; in_tag = 6'd0;
        #12;
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_y", y, 32'd0);
        check("rst_tag", {26'd0, out_tag}, 32'd0);
        check("rst_dz", {31'd0, dz_flag}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        rstn = 1'b1;
        @(negedge clk);
        check("idle_in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;

        // Latency: valid exactly LAT edges after accept
        send(32'h40C0_0000, 32'h4000_0000, 6'd5, 32'h4040_0000, 1'b0, 0, 1'b1, c0);
        for (int i = 1; i <= LAT; i++) begin
            @(posedge clk); @(negedge clk);
            check($sformatf("lat_valid_%0d", i), {31'd0, out_valid}, {31'd0, i == LAT});
        end
        @(posedge clk); @(negedge clk);
        check("post_valid", {31'd0, out_valid}, 32'd0);
        check("post_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;

        // Back-to-back throughput and value patterns
        send(32'h3F80_0000, 32'h4040_0000, 6'd1, 32'h3EAA_AAAB, 1'b0, 7, 1'b1, c1);
        send(32'hBF80_0000, 32'h4040_0000, 6'd2, 32'hBEAA_AAAB, 1'b0, 7, 1'b1, c2);
        check("throughput", c2 - c1, LAT + 1);
        send(32'h4110_0000, 32'h4040_0000, 6'd3, 32'h4040_0000, 1'b0, 7, 1'b1, c0);
        send(32'h3F80_0000, 32'h3F00_0000, 6'd63, 32'h4000_0000, 1'b0, 7, 1'b1, c0);
        send(32'h40C0_0000, 32'hC000_0000, 6'd4, 32'hC040_0000, 1'b0, 7, 1'b1, c0);
        wait_drain();

        // Backpressure: result held, second op waits, accepted on the release cycle
        out_ready = 1'b0;
        send(32'h40C0_0000, 32'h4000_0000, 6'd12, 32'h4040_0000, 1'b0, 0, 1'b1, c0);
        x1 = 32'h4110_0000; x2 = 32'h4040_0000; in_tag = 6'd13; in_valid = 1'b1;
        wait_valid();
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); @(negedge clk);
            check("bp_y", y, 32'h4040_0000);
            check("bp_tag", {26'd0, out_tag}, 32'd12);
            check("bp_in_ready", {31'd0, in_ready}, 32'd0);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_release_ready", {31'd0, in_ready}, 32'd1);
        q.push_back('{32'h4040_0000, 6'd13, 1'b0, 0});
        @(posedge clk); #1;
        in_valid = 1'b0;
        wait_drain();

        // Flush while counter is 1 in CALC
        send(32'h40C0_0000, 32'h4000_0000, 6'd20, 32'd0, 1'b0, 0, 1'b0, c0);
        @(posedge clk); #1;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        @(negedge clk);
        check("flush_calc_busy", {31'd0, busy}, 32'd0);
        hi_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (out_valid) hi_cnt++;
        end
        check("flush_calc_no_valid", hi_cnt, 32'd0);
        @(posedge clk); #1;

        // Flush in DONE with a new op offered
        out_ready = 1'b0;
        send(32'h40C0_0000, 32'h4000_0000, 6'd21, 32'd0, 1'b0, 0, 1'b0, c0);
        wait_valid();
        @(posedge clk); #1;
        flush = 1'b1; in_valid = 1'b1; x1 = 32'h3F80_0000; x2 = 32'h4040_0000;
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        check("flush_done_busy", {31'd0, busy}, 32'd0);
        check("flush_done_valid", {31'd0, out_valid}, 32'd0);
        @(posedge clk); #1;
        out_ready = 1'b1;

        // Flush in IDLE forces in_ready low
        flush = 1'b1; in_valid = 1'b1;
        @(negedge clk);
        check("flush_in_ready", {31'd0, in_ready}, 32'd0);
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        check("flush_idle_busy", {31'd0, busy}, 32'd0);
        @(posedge clk); #1;

        // Asynchronous reset mid-CALC
        send(32'h3F80_0000, 32'h4040_0000, 6'd30, 32'd0, 1'b0, 0, 1'b0, c0);
        #2;
        rstn = 1'b0;
        #1;
        check("arst_y", y, 32'd0);
        check("arst_tag", {26'd0, out_tag}, 32'd0);
        check("arst_valid", {31'd0, out_valid}, 32'd0);
        check("arst_busy", {31'd0, busy}, 32'd0);
        check("arst_dz", {31'd0, dz_flag}, 32'd0);
        #2;
        rstn = 1'b1;
        @(posedge clk); #1;
        send(32'h40C0_0000, 32'h4000_0000, 6'd7, 32'h4040_0000, 1'b0, 0, 1'b1, c0);
        wait_drain();

`ifdef FDIV_SPECIAL_EN
        send(32'h3F80_0000, 32'h0000_0000, 6'd40, 32'h7F80_0000, 1'b1, 0, 1'b1, c0);
        send(32'h8000_0000, 32'h4000_0000, 6'd41, 32'h8000_0000, 1'b0, 0, 1'b1, c0);
        send(32'h0000_0000, 32'h0000_0000, 6'd42, 32'h7FC0_0000, 1'b1, 0, 1'b1, c0);
        wait_drain();
`endif

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end
endmodule

// File: doc/fdiv_seq.md
Name: fdiv_seq

Overview:
- Multi-cycle issue/result stage that sits directly upstream of the combinational fdiv core and owns its operand and result registers.
- Accepts one divide op (two IEEE-754 single operands plus a register tag) over a valid/ready handshake and drives the registered operands into an internal fdiv instance.
- Waits a fixed number of cycles, treating fdiv as a multicycle path, then presents the registered result and tag to FPU writeback until accepted.

Parameters:
- LATENCY, 3, cycles from operand capture to result capture; legal range 1..15.
- TAG_W, 6, width of the destination-register tag carried alongside the op.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rstn  input  1  reset, asynchronous, active-low.
- flush  input  1  synchronous kill of any in-flight or pending op.
- in_valid  input  1  operands and tag presented.
- in_ready  output  1  stage can accept an op this cycle.
- x1  input  32  dividend.
- x2  input  32  divisor.
- in_tag  input  TAG_W  destination tag.
- out_valid  output  1  result valid.
- out_ready  input  1  writeback accepts the result.
- y  output  32  quotient, registered.
- out_tag  output  TAG_W  tag of the result, registered.
- dz_flag  output  1  divide-by-zero indication, registered.
- busy  output  1  high in CALC or DONE.

Behaviour:
- Reset: clk and rstn only; reset is asynchronous and active-low. While rstn=0: state=IDLE, counter=0, out_valid=0, y=0, out_tag=0, dz_flag=0, operand regs=0. in_ready=1 once rstn is released.
- States:
  - IDLE: in_ready=1. On in_valid&in_ready, latch x1, x2, in_tag into operand regs; counter<=LATENCY-1; go to CALC.
  - CALC: in_ready=0. Operand regs drive the fdiv instance and stay stable for the whole state. If counter!=0, decrement. If counter==0, capture fdiv y into y, the tag into out_tag, and the flag into dz_flag; set out_valid=1; go to DONE.
  - DONE: out_valid=1; y, out_tag and dz_flag stay stable until the handshake.
    - out_ready=1: clear out_valid. If in_valid is also high, accept the new op the same cycle and go to CALC; otherwise go to IDLE.
    - out_ready=0: in_ready=0.
- in_ready is combinational: (state==IDLE) | (state==DONE & out_ready). It never depends on in_valid.
- Timing: an op accepted at edge k gives out_valid=1 after edge k+LATENCY. Back-to-back throughput is one op per LATENCY+1 cycles when out_ready is held high.
- flush:
  - Has priority over every other event. Next state is IDLE and out_valid is 0 after the edge.
  - An in_valid in the same cycle is not accepted, and in_ready is forced to 0 while flush=1.
  - y and out_tag keep their old values but are don't-care.
- Reset mid-CALC: the op is lost and no out_valid is produced.
- The counter is 4 bits wide. LATENCY=1 gives counter=0 on entry, so the result is captured on the first CALC edge.
- Arithmetic is fully delegated to fdiv. The result must match IEEE round-to-nearest within ±7 ulp on the low bits for normal/zero dividends and normal divisors. NaN, Inf and exponent-255 operands give an undefined y.
- dz_flag=0 whenever FDIV_SPECIAL_EN is undefined.

Optional Feature:
- Macro: FDIV_SPECIAL_EN.
- Defined: special-case logic at result capture overrides the fdiv output:
  - divisor exponent==0 and dividend exponent!=0: y={x1[31]^x2[31],8'hFF,23'b0}, dz_flag=1.
  - dividend exponent==0: y={sign,31'b0}, dz_flag=0.
  - both exponents 0: y=32'h7FC00000, dz_flag=1.
- Not defined: y is always the raw fdiv output, dz_flag is tied to 0, and no extra logic is built.

Test Plan:
- x1=0x40C00000 (6.0), x2=0x40000000 (2.0), tag=5, out_ready=1, LATENCY=3 -> out_valid rises exactly 3 edges after accept; y=0x40400000, out_tag=5; then out_valid drops and in_ready=1.
- x1=0x3F800000, x2=0x40400000 -> y within ±7 of 0x3EAAAAAB. Sign sweep: x1=0xBF800000 -> y[31]=1.
- Backpressure: hold out_ready=0 for 10 cycles -> y and out_tag stable, in_ready=0, second in_valid not accepted. Raising out_ready together with in_valid -> new op accepted the same cycle.
- Flush in CALC (counter=1) -> out_valid never asserts, state IDLE next cycle. Flush in DONE with in_valid=1 -> nothing accepted.
- rstn low asynchronously mid-CALC -> outputs zero immediately without a clock edge. After release, a fresh 6.0/2.0 op completes normally.
- With FDIV_SPECIAL_EN defined: 0x3F800000/0x00000000 -> y=0x7F800000, dz_flag=1; 0x80000000/0x40000000 -> y=0x80000000, dz_flag=0. Without the macro, dz_flag stays 0 throughout all tests.
